count_sampler: RTL and testbench
================================

# count_sampler

Synchronous capture stage directly downstream of the 6-bit JK ripple counter. It brings the counter's asynchronous, glitch-prone parallel output into the `clk` domain, accepts a value only once it has been stable for two consecutive samples, and delivers each new accepted value over a valid/ready handshake. It also flags a programmable limit match and counts counter wrap-arounds.

## Interface
- `WIDTH`, 6: width of the counter value.
- `WRAP_W`, 8: width of the wrap counter.

- `clk`  in  1  system clock, rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `cnt_in`  in  WIDTH  raw ripple-counter value (Q outputs, LSB = first stage); asynchronous to `clk`.
- `enable`  in  1  acceptance enable.
- `limit`  in  WIDTH  match threshold; quasi-static.
- `value`  out  WIDTH  delivered counter value.
- `valid`  out  1  `value` holds an undelivered sample.
- `ready`  in  1  consumer accepts `value`.
- `match`  out  1  one-cycle pulse; accepted value became equal to `limit`.
- `wraps`  out  WRAP_W  saturating count of counter wrap-arounds.
- `wrap_ovf`  out  1  sticky; a wrap occurred while `wraps` was at its maximum.

## Operation
- Sync chain, always running: `cnt_in` → `s1` → `s2` → `s2_prev`, all per bit.
- Stability filter: `s2 == s2_prev` marks a stable candidate.
- Registers:
  - `acc` holds the last accepted stable value.
  - `last_dlv` holds the last delivered value.
- Acceptance occurs when `enable`=1 and the candidate is stable and `s2 != acc`. On acceptance:
  - `acc` ← `s2`.
  - Wrap: if `s2 < acc` (unsigned), `wraps` increments. If `wraps` is already all-ones it holds and `wrap_ovf` ← 1. `wrap_ovf` clears only on reset.
  - Match: if `s2 == limit`, `match` is 1 for exactly one cycle.
- FSM:
  - IDLE: `valid`=0. Enters SAMPLE when `enable`=1.
  - SAMPLE: when `acc != last_dlv` (including an acceptance in this same cycle), then `value` ← the newest accepted value, `last_dlv` ← that value, `valid` ← 1, go to HOLD. If `enable`=0, go to IDLE.
  - HOLD: `value` and `valid` are frozen. Acceptances continue to update `acc`, `wraps` and `match`. Intermediate values are dropped; only the newest is delivered afterwards. When `valid` && `ready` at an edge, `valid` ← 0 and the FSM goes to SAMPLE, or to IDLE if `enable`=0.
- `enable` falling in HOLD does not abort the transfer; the handshake still completes.
- Re-enable compares against the pre-disable `acc`, so one wrap is counted if the value decreased while disabled.
- `value` is never changed while `valid`=1.

## Timing
- Reset (`clear`=0): immediate, independent of `clk`.
  - All outputs go to 0: `value`, `valid`, `match`, `wraps`, `wrap_ovf`.
  - `s1`, `s2`, `s2_prev`, `acc` and `last_dlv` go to 0. State goes to IDLE.
  - Release is sampled at the next rising edge.
- Latency: suppose `cnt_in` settles before edge N and stays constant.
  - `s1` at N, `s2` at N+1, `s2_prev` at N+2.
  - Acceptance, `match` and `wraps` update at edge N+3.
  - `valid` rises at N+3 if in SAMPLE: 3 clocks input-to-valid.
- A value that changes again before N+2 is never accepted. Ripple glitches shorter than one clock are filtered.
- Throughput: at most one delivery every 2 cycles, because a handshake completing at edge E returns to SAMPLE and the next `valid` rises at E+1 at the earliest.
- `ready` is a don't-care unless `valid`=1. There is no combinational path from `ready` to `valid` or `value`.
- A value equal to `last_dlv` is not redelivered. A value equal to the reset value 0 is not delivered until a different value has been.

## Test plan
- Reset mid-HOLD: with `valid`=1 and `value`=5, pull `clear` low between edges → all outputs go to 0 before the next edge. After release, 0 is not delivered.
- Latency: `enable`=1, `ready`=1, `cnt_in` steps 0→3 before edge N → `valid`=1 and `value`=3 after edge N+3 and not before. `valid`=0 after N+4.
- Glitch filter: `cnt_in` = 7 for one cycle, then back to 0 → no acceptance, `valid` stays 0.
- Backpressure: `ready`=0, `cnt_in` steps 1→2→3, each value held for 4 cycles → `value` stays 1 until `ready` is raised. The next delivery is 3; 2 is never delivered.
- Wrap and match: `limit`=62, `cnt_in` sweeps 60→61→62→63→0→1, each held for 4 cycles → `match` pulses once at acceptance of 62. `wraps` goes 0→1 at acceptance of 0.
- Saturation: drive 256 wraps with `WRAP_W`=8 → `wraps`=255 and `wrap_ovf`=1, both holding through further wraps.

Source files
------------

// File: rtl/count_sampler_if.sv
// Delivery channel of count_sampler: one WIDTH-bit value under valid/ready.
// Transfer happens on a rising clk edge where valid && ready; value is stable while valid=1.
interface count_sampler_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] value;
    logic             valid;
    logic             ready;

    modport master (output value, output valid, input ready);
    modport slave  (input value, input valid, output ready);
endinterface

// File: rtl/count_sampler.sv
// Samples a ripple counter into clk, accepts values stable for two samples,
// delivers newest accepted value over valid/ready, flags limit match, counts wraps.
module count_sampler #(
    parameter int WIDTH  = 6,
    parameter int WRAP_W = 8
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [WIDTH-1:0]    cnt_in,
    input  logic                enable,
    input  logic [WIDTH-1:0]    limit,
    count_sampler_if.master     dlv,
    output logic                match,
    output logic [WRAP_W-1:0]   wraps,
    output logic                wrap_ovf,
    output logic [1:0]          state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, SAMPLE = 2'd1, HOLD = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] s1, s2, s2_prev;
    logic [WIDTH-1:0] acc, last_dlv, value_q;
    logic             valid_q;
    logic             stable, accept;
    logic [WIDTH-1:0] newest;
    logic             deliver, handshake;

    always_comb begin
        stable = (s2 == s2_prev);
        accept = enable && stable && (s2 != acc);
        // A value accepted on this edge is deliverable on the same edge.
        newest = accept ? s2 : acc;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = SAMPLE;
            SAMPLE: begin
                if (newest != last_dlv) state_nxt = HOLD;
                else if (!enable)       state_nxt = IDLE;
            end
            HOLD:    if (valid_q && dlv.ready) state_nxt = enable ? SAMPLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        deliver   = 1'b0;
        handshake = 1'b0;
        case (state)
            SAMPLE:  deliver   = (newest != last_dlv);
            HOLD:    handshake = valid_q && dlv.ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            s1       <= '0;
            s2       <= '0;
            s2_prev  <= '0;
            acc      <= '0;
            match    <= 1'b0;
            wraps    <= '0;
            wrap_ovf <= 1'b0;
        end else begin
            s1      <= cnt_in;
            s2      <= s1;
            s2_prev <= s2;
            match   <= accept && (s2 == limit);
            if (accept) begin
                acc <= s2;
                // A decrease between accepted values means the counter wrapped.
                if (s2 < acc) begin
                    if (&wraps) wrap_ovf <= 1'b1;
                    else        wraps    <= wraps + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            last_dlv <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
        end else if (deliver) begin
            last_dlv <= newest;
            value_q  <= newest;
            valid_q  <= 1'b1;
        end else if (handshake) begin
            valid_q  <= 1'b0;
        end
    end

    assign dlv.value = value_q;
    assign dlv.valid = valid_q;
    assign state_dbg = state;
endmodule

// File: tb/tb_count_sampler.sv
// Directed bench for count_sampler: reset, latency, glitch filter, backpressure,
// wrap/match sweep, wrap saturation and asynchronous reset during HOLD.
module tb_count_sampler;
    localparam int WIDTH  = 6;
    localparam int WRAP_W = 8;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_SAMPLE = 2'd1, ST_HOLD = 2'd2;

    logic              clk = 1'b0;
    logic              clear;
    logic [WIDTH-1:0]  cnt_in;
    logic              enable;
    logic [WIDTH-1:0]  limit;
    logic              match;
    logic [WRAP_W-1:0] wraps;
    logic              wrap_ovf;
    logic [1:0]        state_dbg;

    count_sampler_if #(.WIDTH(WIDTH)) bus ();

    count_sampler #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
        .clk       (clk),
        .clear     (clear),
        .cnt_in    (cnt_in),
        .enable    (enable),
        .limit     (limit),
        .dlv       (bus.master),
        .match     (match),
        .wraps     (wraps),
        .wrap_ovf  (wrap_ovf),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit after the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".value"},    32'(bus.value), 0);
        check({tag, ".valid"},    32'(bus.valid), 0);
        check({tag, ".match"},    32'(match),     0);
        check({tag, ".wraps"},    32'(wraps),     0);
        check({tag, ".wrap_ovf"}, 32'(wrap_ovf),  0);
        check({tag, ".state"},    32'(state_dbg), 32'(ST_IDLE));
    endtask

    int                exp_wraps;
    logic              exp_ovf;
    logic [WIDTH-1:0]  sweep [6];

    initial begin
        clear      = 1'b1;
        cnt_in     = '0;
        enable     = 1'b0;
        limit      = '0;
        bus.ready  = 1'b0;
        exp_wraps  = 0;
        exp_ovf    = 1'b0;

        // Reset state
        #2 clear = 1'b0;
        #2 check_zero("reset");
        #8 clear = 1'b1;
        enable    = 1'b1;
        bus.ready = 1'b1;
        step(6);
        check("idle_no_zero.valid", 32'(bus.valid), 0);
        check("idle_no_zero.state", 32'(state_dbg), 32'(ST_SAMPLE));

        // Latency: 0 -> 3 before edge N, valid after N+3 only
        cnt_in = 6'd3;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            check("latency.early_valid", 32'(bus.valid), 0);
        end
        step(1);
        check("latency.valid", 32'(bus.valid), 1);
        check("latency.value", 32'(bus.value), 3);
        check("latency.state", 32'(state_dbg), 32'(ST_HOLD));
        step(1);
        check("latency.drop",  32'(bus.valid), 0);
        check("latency.back",  32'(state_dbg), 32'(ST_SAMPLE));

        // Glitch: 7 for one cycle then back to 3
        cnt_in = 6'd7;
        step(1);
        cnt_in = 6'd3;
        for (int k = 0; k < 6; k++) begin
            step(1);
            check("glitch.valid", 32'(bus.valid), 0);
            check("glitch.match", 32'(match), 0);
        end
        check("glitch.wraps", 32'(wraps), 0);

        // Backpressure: 1, 2, 3 with ready low; 3 < previous 3? no, 1 < 3 wraps once
        bus.ready = 1'b0;
        cnt_in = 6'd1;
        step(4);
        exp_wraps = 1;
        check("bp.valid1", 32'(bus.valid), 1);
        check("bp.value1", 32'(bus.value), 1);
        cnt_in = 6'd2;
        step(4);
        check("bp.hold2.valid", 32'(bus.valid), 1);
        check("bp.hold2.value", 32'(bus.value), 1);
        cnt_in = 6'd3;
        step(4);
        check("bp.hold3.value", 32'(bus.value), 1);
        check("bp.wraps", 32'(wraps), 32'(exp_wraps));
        bus.ready = 1'b1;
        step(1);
        check("bp.release.valid", 32'(bus.valid), 0);
        step(1);
        check("bp.next.valid", 32'(bus.valid), 1);
        check("bp.next.value", 32'(bus.value), 3);
        step(1);
        check("bp.next.drop", 32'(bus.valid), 0);

        // Wrap and match sweep
        limit = 6'd62;
        sweep[0] = 6'd60; sweep[1] = 6'd61; sweep[2] = 6'd62;
        sweep[3] = 6'd63; sweep[4] = 6'd0;  sweep[5] = 6'd1;
        for (int i = 0; i < 6; i++) begin
            cnt_in = sweep[i];
            for (int k = 1; k <= 4; k++) begin
                step(1);
                check("sweep.match", 32'(match), 32'((sweep[i] == 6'd62) && (k == 4)));
            end
            if (sweep[i] == 6'd0) exp_wraps++;
            check("sweep.wraps", 32'(wraps), 32'(exp_wraps));
            check("sweep.value", 32'(bus.value), 32'(sweep[i]));
            check("sweep.valid", 32'(bus.valid), 1);
        end
        check("sweep.ovf", 32'(wrap_ovf), 0);

        // Saturation: 10 -> 5 is one wrap per iteration
        limit = 6'd40;
        for (int i = 0; i < 258; i++) begin
            cnt_in = 6'd10;
            step(4);
            cnt_in = 6'd5;
            step(4);
            if (exp_wraps == 255) exp_ovf = 1'b1;
            else                  exp_wraps++;
            check("sat.wraps", 32'(wraps),    32'(exp_wraps));
            check("sat.ovf",   32'(wrap_ovf), 32'(exp_ovf));
        end
        check("sat.final_wraps", 32'(wraps), 255);
        check("sat.final_ovf",   32'(wrap_ovf), 1);

        // Reset in the middle of HOLD with value 5
        cnt_in = 6'd20;
        step(4);
        step(1);
        check("rst_hold.pre_drop", 32'(bus.valid), 0);
        bus.ready = 1'b0;
        cnt_in = 6'd5;
        step(4);
        check("rst_hold.valid", 32'(bus.valid), 1);
        check("rst_hold.value", 32'(bus.value), 5);
        check("rst_hold.state", 32'(state_dbg), 32'(ST_HOLD));
        #3 clear = 1'b0;
        cnt_in = 6'd0;
        #1 check_zero("rst_hold.async");
        #3 clear = 1'b1;
        bus.ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1);
            check("rst_hold.no_zero", 32'(bus.valid), 0);
        end
        check("rst_hold.wraps", 32'(wraps), 0);
        check("rst_hold.ovf",   32'(wrap_ovf), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
